// File: rtl/i8080_rx_ctrl.sv
// -----------------------------------------------------------------------------
// i8080_rx_ctrl
//
// Front end of the display path. The host MCU drives an asynchronous 8-bit
// i8080 write bus. This block oversamples that bus on the system clock,
// decodes a small command set and forwards RAMWR pixel bytes into the 8-bit
// write port of the display FIFO. It also owns the LCD backlight (enable plus
// 8-bit PWM brightness) and flags frame start, frame done and FIFO overflow.
//
// Ports:
//   CLK          system clock, the only clock
//   RST          synchronous active-high reset
//   I80_nCS      host chip select, active low, asynchronous
//   I80_nWR      host write strobe, active low, data valid on its rising edge
//   I80_DC       data/command select (0 = command, 1 = data)
//   I80_D[7:0]   host data bus
//   FIFO_FULL    display FIFO full flag
//   FIFO_WE      FIFO write enable, one cycle per accepted pixel byte
//   FIFO_DI[7:0] FIFO write data
//   FRAME_START  one-cycle pulse on each RAMWR (0x2C) command
//   FRAME_DONE   one-cycle pulse on the byte that completes a frame
//   OVF          sticky flag, a pixel byte was dropped on a full FIFO
//   LCD_BL       backlight PWM output
//
// Optional feature macro: I80_AUTO_STOP_EN
//   defined   : after the last byte of a frame the block returns to IDLE and
//               ignores pixel data until the next 0x2C or 0x3C.
//   undefined : the byte counter wraps and pixel data keeps streaming into
//               the next frame without a new command.
// -----------------------------------------------------------------------------

`default_nettype none

module i8080_rx_ctrl #(
  parameter int SYNC_STAGES   = 2,
  parameter int H_RES         = 800,
  parameter int V_RES         = 480,
  parameter int BYTES_PER_PIX = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       I80_nCS,
  input  logic       I80_nWR,
  input  logic       I80_DC,
  input  logic [7:0] I80_D,
  input  logic       FIFO_FULL,
  output logic       FIFO_WE,
  output logic [7:0] FIFO_DI,
  output logic       FRAME_START,
  output logic       FRAME_DONE,
  output logic       OVF,
  output logic       LCD_BL
);

  // Bytes in one full frame and the counter width needed to hold it.
  localparam int TC    = H_RES * V_RES * BYTES_PER_PIX;
  localparam int CNT_W = $clog2(TC + 1);
  localparam logic [CNT_W-1:0] TC_LAST = CNT_W'(TC - 1);

  // Command opcodes understood by this block.
  localparam logic [7:0] CMD_RAMWR  = 8'h2C;
  localparam logic [7:0] CMD_RAMWRC = 8'h3C;
  localparam logic [7:0] CMD_BRIGHT = 8'h51;
  localparam logic [7:0] CMD_DISPON = 8'h29;
  localparam logic [7:0] CMD_DISPOF = 8'h28;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RAMWR    = 2'd1,
    PARAM_BL = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizer
  // ---------------------------------------------------------------------------
  // Index 0 is the first flop, SYNC_STAGES-1 the last. nCS and nWR reset to
  // their idle (high) level so no false strobe appears as reset releases.
  logic [SYNC_STAGES-1:0] ncs_sync;
  logic [SYNC_STAGES-1:0] nwr_sync;
  logic [SYNC_STAGES-1:0] dc_sync;
  logic [7:0]             d_sync [SYNC_STAGES];

  always_ff @(posedge CLK) begin
    if (RST) begin
      ncs_sync <= '1;
      nwr_sync <= '1;
      dc_sync  <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        d_sync[i] <= 8'h00;
      end
    end else begin
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], I80_nCS};
      nwr_sync  <= {nwr_sync[SYNC_STAGES-2:0], I80_nWR};
      dc_sync   <= {dc_sync[SYNC_STAGES-2:0], I80_DC};
      d_sync[0] <= I80_D;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        d_sync[i] <= d_sync[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Write strobe detection
  // ---------------------------------------------------------------------------
  // nwr_prev extends the nWR chain by one flop so the rising edge is seen
  // between two stable stages. DC and D are captured from the same stage as
  // the edge, which keeps them aligned with the strobe that qualifies them.
  logic       nwr_prev;
  logic       wr_stb;
  logic       stb_dc;
  logic [7:0] stb_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      nwr_prev <= 1'b1;
      wr_stb   <= 1'b0;
      stb_dc   <= 1'b0;
      stb_d    <= 8'h00;
    end else begin
      nwr_prev <= nwr_sync[SYNC_STAGES-1];
      wr_stb   <= nwr_sync[SYNC_STAGES-1] & ~nwr_prev & ~ncs_sync[SYNC_STAGES-1];
      stb_dc   <= dc_sync[SYNC_STAGES-1];
      stb_d    <= d_sync[SYNC_STAGES-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Command / data decoder registers
  // ---------------------------------------------------------------------------
  state_t           state, state_next;
  logic [CNT_W-1:0] byte_cnt, byte_cnt_next;
  logic             bl_en, bl_en_next;
  logic [7:0]       duty, duty_next;
  logic             ovf_next;
  logic             fifo_we_next;
  logic [7:0]       fifo_di_next;
  logic             frame_start_next;
  logic             frame_done_next;

  // All decoder state and the FIFO-side outputs are registered together, so
  // a reset on the cycle a strobe is being processed suppresses the write.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      byte_cnt    <= '0;
      bl_en       <= 1'b0;
      duty        <= 8'hFF;
      OVF         <= 1'b0;
      FIFO_WE     <= 1'b0;
      FIFO_DI     <= 8'h00;
      FRAME_START <= 1'b0;
      FRAME_DONE  <= 1'b0;
    end else begin
      state       <= state_next;
      byte_cnt    <= byte_cnt_next;
      bl_en       <= bl_en_next;
      duty        <= duty_next;
      OVF         <= ovf_next;
      FIFO_WE     <= fifo_we_next;
      FIFO_DI     <= fifo_di_next;
      FRAME_START <= frame_start_next;
      FRAME_DONE  <= frame_done_next;
    end
  end

  // Next-state and output decode. Commands are honoured in every state; data
  // bytes mean different things depending on which command preceded them.
  // A pixel byte always advances the counter, even when it is dropped on a
  // full FIFO, so the host's idea of frame position stays correct.
  always_comb begin
    state_next       = state;
    byte_cnt_next    = byte_cnt;
    bl_en_next       = bl_en;
    duty_next        = duty;
    ovf_next         = OVF;
    fifo_we_next     = 1'b0;
    fifo_di_next     = FIFO_DI;
    frame_start_next = 1'b0;
    frame_done_next  = 1'b0;

    if (wr_stb) begin
      if (!stb_dc) begin
        case (stb_d)
          CMD_RAMWR: begin
            state_next       = RAMWR;
            byte_cnt_next    = '0;
            ovf_next         = 1'b0;
            frame_start_next = 1'b1;
          end
          CMD_RAMWRC: begin
            state_next = RAMWR;
          end
          CMD_BRIGHT: begin
            state_next = PARAM_BL;
          end
          CMD_DISPON: begin
            bl_en_next = 1'b1;
            state_next = IDLE;
          end
          CMD_DISPOF: begin
            bl_en_next = 1'b0;
            state_next = IDLE;
          end
          default: begin
            state_next = IDLE;
          end
        endcase
      end else begin
        case (state)
          PARAM_BL: begin
            duty_next  = stb_d;
            state_next = IDLE;
          end
          RAMWR: begin
            if (!FIFO_FULL) begin
              fifo_we_next = 1'b1;
              fifo_di_next = stb_d;
            end else begin
              ovf_next = 1'b1;
            end
            // The counter wraps at the frame boundary in both build modes so
            // a later 0x3C resumes cleanly at the start of the next frame.
            if (byte_cnt == TC_LAST) begin
              byte_cnt_next   = '0;
              frame_done_next = 1'b1;
`ifdef I80_AUTO_STOP_EN
              state_next      = IDLE;
`else
              state_next      = RAMWR;
`endif
            end else begin
              byte_cnt_next = byte_cnt + 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Backlight PWM
  // ---------------------------------------------------------------------------
  // Free-running 8-bit counter. duty=0xFF is treated as fully on rather than
  // 255/256 so the maximum brightness has no ripple; duty=0 is fully off.
  logic [7:0] pwm_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      pwm_cnt <= 8'h00;
      LCD_BL  <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      LCD_BL  <= bl_en & ((pwm_cnt < duty) | (duty == 8'hFF));
    end
  end

endmodule

`default_nettype wire

// File: doc/i8080_rx_ctrl.md
Name: i8080_rx_ctrl

Overview:
- Upstream front end of the display path. Receives the host MCU's 8-bit i8080 write bus (nCS/nWR/DC/D) asynchronously and oversamples it on the fast system clock.
- Decodes a minimal command set and forwards RAMWR pixel bytes as single-cycle writes into the 8-bit write port of the display FIFO. The RGB timing generator drains that FIFO 16 bits at a time.
- Also owns the LCD backlight (on/off plus 8-bit PWM brightness) and reports frame start/done and FIFO overflow.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the input synchronizer (range 2 to 4).
- H_RES, 800, active pixels per line.
- V_RES, 480, active lines per frame.
- BYTES_PER_PIX, 2, bytes per pixel (RGB565). Terminal byte count TC = H_RES*V_RES*BYTES_PER_PIX.

Ports:
- CLK  in  1  system clock (100 MHz); the only clock.
- RST  in  1  synchronous, active-high reset.
- I80_nCS  in  1  host chip select, active low, asynchronous.
- I80_nWR  in  1  host write strobe, active low; data is valid on its rising edge.
- I80_DC  in  1  data/command select: 0 = command, 1 = data.
- I80_D  in  8  host data bus.
- FIFO_FULL  in  1  display FIFO full flag.
- FIFO_WE  out  1  FIFO write enable, one cycle per accepted byte.
- FIFO_DI  out  8  FIFO write data.
- FRAME_START  out  1  one-cycle pulse on each RAMWR (0x2C) command.
- FRAME_DONE  out  1  one-cycle pulse when the byte count reaches TC.
- OVF  out  1  sticky flag: a byte was dropped because FIFO_FULL was high.
- LCD_BL  out  1  backlight PWM output.

Behaviour:
- Reset values: FIFO_WE=0, FIFO_DI=0, FRAME_START=0, FRAME_DONE=0, OVF=0, LCD_BL=0.
- Reset internals: state=IDLE, byte_cnt=0, bl_en=0, duty=8'hFF, PWM counter=0.
- Synchronizer: nCS, nWR, DC and D pass through SYNC_STAGES flops. The resynchronized nCS/nWR reset to 1.
- Strobe: wr_stb is asserted when the synchronized nWR shows 0->1 between its last two stages while the synchronized nCS is 0. DC and D are taken from the same pipeline stage as the nWR edge, so they stay aligned.
- Host rules: nWR low and high times must each be at least SYNC_STAGES+1 CLK cycles. Shorter pulses are undefined and not checked.
- States: IDLE, RAMWR, PARAM_BL.
- Command byte (DC=0), accepted in any state:
  - 0x2C: go to RAMWR, byte_cnt=0, clear OVF, pulse FRAME_START.
  - 0x3C: go to RAMWR with byte_cnt kept.
  - 0x51: go to PARAM_BL.
  - 0x29: bl_en=1, then IDLE.
  - 0x28: bl_en=0, then IDLE.
  - Any other command: IDLE.
- Data byte (DC=1):
  - In IDLE: ignored.
  - In PARAM_BL: duty=D, then IDLE.
  - In RAMWR with FIFO_FULL=0: FIFO_WE=1 and FIFO_DI=D on the cycle after wr_stb; byte_cnt increments.
  - In RAMWR with FIFO_FULL=1: byte dropped, OVF=1, byte_cnt still increments so frame alignment is kept.
- Latency: FIFO_WE rises SYNC_STAGES+2 CLK cycles after the external nWR rising edge.
- Terminal count: on the byte that makes byte_cnt=TC, pulse FRAME_DONE on the same cycle as that byte's FIFO_WE. The action after that is set by I80_AUTO_STOP_EN.
- nCS deasserted mid-burst: state, byte_cnt and duty are all retained. Strobes are ignored while nCS is high.
- RST mid-frame: every register returns to its reset value on the next edge. No FIFO write is issued on the reset cycle.
- PWM: 8-bit free-running counter. LCD_BL = bl_en & ((cnt < duty) | (duty==8'hFF)), registered. duty=0 gives constant 0.

Optional Feature:
- Macro: I80_AUTO_STOP_EN.
- Defined: at byte_cnt=TC, go to IDLE. Further data bytes are ignored until the next 0x2C or 0x3C.
- Undefined: at byte_cnt=TC, byte_cnt wraps to 0 and the state stays RAMWR. FRAME_DONE pulses at every wrap; FRAME_START pulses only on 0x2C.

Test Plan:
- Cmd 0x2C, then data 0x12, 0x34, FIFO not full -> FRAME_START one cycle; FIFO_WE pulses twice with FIFO_DI=0x12 then 0x34, each SYNC_STAGES+2 cycles after its nWR rise.
- Cmd 0x29, cmd 0x51, data 0x40 -> LCD_BL high for 64 of every 256 cycles. Then cmd 0x28 -> LCD_BL stuck at 0.
- FIFO_FULL=1 during the 3rd of 4 RAMWR bytes -> 3 FIFO_WE pulses, OVF=1 and held. Next 0x2C -> OVF=0.
- H_RES=4, V_RES=2, 16 bytes then a 17th -> FRAME_DONE on byte 16.
  - With I80_AUTO_STOP_EN: byte 17 produces no FIFO_WE.
  - Without it: byte 17 is written and byte_cnt=1.
- 0x2C, 5 bytes, nCS high for 20 cycles, 0x3C, 3 bytes -> 8 FIFO writes and a single FRAME_START. Toggling nWR while nCS is high produces no writes.
- RST asserted between bytes 2 and 3 of a RAMWR burst -> all outputs at reset values next cycle. Later data without 0x2C is ignored.
